// File: rtl/video_dma_address_generator.sv
// Multi-channel DMA address generator with CPU/DMA address mux for the video DRAM.
// Each channel has CPU-written shadow registers, plus a live address counter and a beat counter.
module video_dma_address_generator #(
   parameter int ADDR_W = 14,
   parameter int LEN_W  = 16,
   parameter int NUM_CH = 2,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              CLK,
   input  logic              RST_AL,
   input  logic [ADDR_W-1:0] AB,
   input  logic [7:0]        DB,
   input  logic              WR_AL,
   input  logic [CH_W-1:0]   WR_CH,
   input  logic [2:0]        WR_REG,
   input  logic              LDL_AL,
   input  logic              EXCT_SB,
   input  logic              K2,
   input  logic [CH_W-1:0]   DMA_CH,
   output logic [ADDR_W-1:0] ABX,
   output logic [NUM_CH-1:0] BUSY,
   output logic              DONE,
   output logic              WRAP
);

   localparam logic [2:0] REG_START_LO = 3'd0;
   localparam logic [2:0] REG_START_HI = 3'd1;
   localparam logic [2:0] REG_LEN_LO   = 3'd2;
   localparam logic [2:0] REG_LEN_HI   = 3'd3;
   localparam logic [2:0] REG_STRIDE   = 3'd4;
   localparam logic [2:0] REG_MODE     = 3'd5;

   logic [ADDR_W-1:0] start_q  [NUM_CH];
   logic [ADDR_W-1:0] start_d  [NUM_CH];
   logic [LEN_W-1:0]  len_q    [NUM_CH];
   logic [LEN_W-1:0]  len_d    [NUM_CH];
   logic [7:0]        stride_q [NUM_CH];
   logic [7:0]        stride_d [NUM_CH];
   logic [1:0]        mode_q   [NUM_CH];
   logic [1:0]        mode_d   [NUM_CH];
   logic [ADDR_W-1:0] addr_q   [NUM_CH];
   logic [ADDR_W-1:0] addr_d   [NUM_CH];
   logic [LEN_W-1:0]  rem_q    [NUM_CH];
   logic [LEN_W-1:0]  rem_d    [NUM_CH];
   logic [NUM_CH-1:0] busy_q, busy_d;
   logic              done_q, done_d;
   logic              wrap_q, wrap_d;

   logic [NUM_CH-1:0] wsel;
   logic [NUM_CH-1:0] dsel;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_sel
      assign wsel[g] = !WR_AL && (WR_CH == CH_W'(g));
      assign dsel[g] = (DMA_CH == CH_W'(g));
   end

   always_comb begin
      start_d  = start_q;
      len_d    = len_q;
      stride_d = stride_q;
      mode_d   = mode_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      wrap_d   = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (wsel[c]) begin
            case (WR_REG)
               REG_START_LO: start_d[c][7:0]        = DB;
               REG_START_HI: start_d[c][ADDR_W-1:8] = DB[ADDR_W-9:0];
               REG_LEN_LO:   len_d[c][7:0]          = DB;
               REG_LEN_HI:   len_d[c][LEN_W-1:8]    = DB[LEN_W-9:0];
               REG_STRIDE:   stride_d[c]            = DB;
               REG_MODE:     mode_d[c]              = DB[1:0];
               default: ;
            endcase
         end
         // Load beats a same-cycle beat; live counters use the pre-write shadow values.
         if (!LDL_AL && dsel[c]) begin
            addr_d[c] = start_q[c];
            rem_d[c]  = len_q[c];
            busy_d[c] = mode_q[c][1] && (len_q[c] != '0);
         end else if (EXCT_SB && K2 && dsel[c] && busy_q[c]) begin
            if (rem_q[c] > LEN_W'(1)) begin
               addr_d[c] = addr_q[c] + ADDR_W'(stride_q[c]);
               rem_d[c]  = rem_q[c] - LEN_W'(1);
            end else if (mode_q[c][0]) begin
               if (len_q[c] == '0) begin
                  busy_d[c] = 1'b0;
               end else begin
                  addr_d[c] = start_q[c];
                  rem_d[c]  = len_q[c];
                  wrap_d    = 1'b1;
               end
            end else begin
               busy_d[c] = 1'b0;
               done_d    = 1'b1;
            end
         end
         // Software disable is a silent abort: no completion pulse.
         if (wsel[c] && (WR_REG == REG_MODE) && !DB[1]) begin
            busy_d[c] = 1'b0;
            if (dsel[c]) begin
               done_d = 1'b0;
               wrap_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_AL) begin
      if (!RST_AL) begin
         start_q  <= '{default: '0};
         len_q    <= '{default: '0};
         stride_q <= '{default: '0};
         mode_q   <= '{default: '0};
         addr_q   <= '{default: '0};
         rem_q    <= '{default: '0};
         busy_q   <= '0;
         done_q   <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         start_q  <= start_d;
         len_q    <= len_d;
         stride_q <= stride_d;
         mode_q   <= mode_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         wrap_q   <= wrap_d;
      end
   end

   logic [ADDR_W-1:0] dma_addr;

   always_comb begin
      dma_addr = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (dsel[c]) dma_addr = addr_q[c];
      end
   end

   assign ABX  = EXCT_SB ? dma_addr : AB;
   assign BUSY = busy_q;
   assign DONE = done_q;
   assign WRAP = wrap_q;

endmodule

// File: tb/tb_video_dma_address_generator.sv
// Directed bench for video_dma_address_generator: pass-through, linear/wrap DMA,
// channel interleave, collisions and mid-transfer reset.
module tb_video_dma_address_generator;

   logic        CLK = 1'b0;
   logic        RST_AL;
   logic [13:0] AB;
   logic [7:0]  DB;
   logic        WR_AL;
   logic [0:0]  WR_CH;
   logic [2:0]  WR_REG;
   logic        LDL_AL;
   logic        EXCT_SB;
   logic        K2;
   logic [0:0]  DMA_CH;
   logic [13:0] ABX;
   logic [1:0]  BUSY;
   logic        DONE;
   logic        WRAP;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int wrap_cnt = 0;
   int base;

   video_dma_address_generator dut (
      .CLK(CLK), .RST_AL(RST_AL), .AB(AB), .DB(DB), .WR_AL(WR_AL), .WR_CH(WR_CH),
      .WR_REG(WR_REG), .LDL_AL(LDL_AL), .EXCT_SB(EXCT_SB), .K2(K2), .DMA_CH(DMA_CH),
      .ABX(ABX), .BUSY(BUSY), .DONE(DONE), .WRAP(WRAP)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (DONE) done_cnt++;
      if (WRAP) wrap_cnt++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input int ch, input int rg, input int data);
      WR_CH  = ch[0:0];
      WR_REG = rg[2:0];
      DB     = data[7:0];
      WR_AL  = 1'b0;
      tick();
      WR_AL  = 1'b1;
   endtask

   task automatic load(input int ch);
      DMA_CH = ch[0:0];
      LDL_AL = 1'b0;
      tick();
      LDL_AL = 1'b1;
   endtask

   task automatic beat(input int ch);
      DMA_CH  = ch[0:0];
      EXCT_SB = 1'b1;
      K2      = 1'b1;
      tick();
      K2      = 1'b0;
   endtask

   initial begin
      RST_AL = 1'b0; AB = 14'h1ABC; DB = '0; WR_AL = 1'b1; WR_CH = '0; WR_REG = '0;
      LDL_AL = 1'b1; EXCT_SB = 1'b0; K2 = 1'b0; DMA_CH = '0;
      #1;
      chk("rst_abx_cpu", ABX, 'h1ABC);
      EXCT_SB = 1'b1;
      #1;
      chk("rst_abx_dma", ABX, 'h0000);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_wrap", WRAP, 0);
      tick();
      tick();
      RST_AL = 1'b1;
      tick();
      chk("post_rst_abx_dma", ABX, 'h0000);
      EXCT_SB = 1'b0;
      #1;
      chk("cpu_pass", ABX, 'h1ABC);

      // Linear STOP-mode transfer on ch0
      wr(0, 0, 'h00); wr(0, 1, 'h01); wr(0, 2, 4); wr(0, 3, 0); wr(0, 4, 1); wr(0, 5, 'h02);
      chk("lin_busy_before_load", BUSY, 0);
      load(0);
      chk("lin_busy_load", BUSY, 1);
      EXCT_SB = 1'b1; DMA_CH = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("lin_addr%0d", i), ABX, 'h100 + i);
         chk($sformatf("lin_done_low%0d", i), DONE, 0);
         beat(0);
      end
      chk("lin_done_pulse", DONE, 1);
      chk("lin_busy_end", BUSY, 0);
      chk("lin_abx_end", ABX, 'h103);
      beat(0);
      chk("lin_beat5_abx", ABX, 'h103);
      chk("lin_done_once", DONE, 0);
      tick();
      chk("lin_done_cnt", done_cnt, 1);

      // WRAP-mode transfer on ch1 crossing the top of the address space
      wr(1, 0, 'hFE); wr(1, 1, 'h3F); wr(1, 2, 3); wr(1, 3, 0); wr(1, 4, 2); wr(1, 5, 'h03);
      load(1);
      chk("wrap_busy_load", BUSY, 2);
      DMA_CH = 1'b1;
      #1;
      chk("wrap_a0", ABX, 'h3FFE); beat(1);
      chk("wrap_a1", ABX, 'h0000); beat(1);
      chk("wrap_a2", ABX, 'h0002);
      chk("wrap_no_early", WRAP, 0);
      beat(1);
      chk("wrap_a3", ABX, 'h3FFE);
      chk("wrap_pulse", WRAP, 1);
      chk("wrap_busy", BUSY, 2);
      tick();
      chk("wrap_pulse_end", WRAP, 0);
      chk("wrap_cnt", wrap_cnt, 1);

      // Interleave: ch0 reloaded at 0x100, ch1 sits at 0x3FFE
      load(0);
      beat(0);
      chk("il_ch0_a", ABX, 'h101);
      DMA_CH = 1'b1; #1;
      chk("il_ch1_held", ABX, 'h3FFE);
      beat(1);
      chk("il_ch1_a", ABX, 'h0000);
      DMA_CH = 1'b0; #1;
      chk("il_ch0_held", ABX, 'h101);
      beat(0);
      chk("il_ch0_b", ABX, 'h102);
      DMA_CH = 1'b1; #1;
      chk("il_ch1_held2", ABX, 'h0000);

      // Load and beat together on ch1: load wins
      DMA_CH = 1'b1; LDL_AL = 1'b0; K2 = 1'b1;
      tick();
      LDL_AL = 1'b1; K2 = 1'b0;
      chk("col_load_wins", ABX, 'h3FFE);

      // START_LO write while ch0 runs: live address untouched until reload
      wr(0, 0, 'h55);
      DMA_CH = 1'b0; #1;
      chk("col_wr_live", ABX, 'h102);
      beat(0);
      chk("col_wr_beat", ABX, 'h103);
      load(0);
      chk("col_wr_reload", ABX, 'h155);
      chk("col_busy0", BUSY[0], 1);

      // Zero-length load never starts a channel
      base = done_cnt;
      wr(1, 2, 0);
      load(1);
      chk("len0_busy1", BUSY[1], 0);
      beat(1);
      chk("len0_abx", ABX, 'h3FFE);
      tick(); tick();
      chk("len0_no_done", done_cnt, base);

      // Clearing EN aborts ch0 silently
      wr(0, 5, 'h00);
      chk("en_clr_busy", BUSY[0], 0);
      tick();
      chk("en_clr_no_done", done_cnt, base);

      // Reset with two beats remaining on ch0
      wr(0, 5, 'h02);
      load(0);
      beat(0); beat(0);
      chk("pre_rst_addr", ABX, 'h157);
      chk("pre_rst_busy", BUSY[0], 1);
      #2;
      RST_AL = 1'b0;
      #1;
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_abx", ABX, 'h0000);
      tick(); tick();
      RST_AL = 1'b1;
      tick();
      load(0);
      chk("post_rst_shadow_busy", BUSY, 0);
      chk("post_rst_shadow_addr", ABX, 'h0000);
      tick();
      chk("final_done_cnt", done_cnt, 1);
      chk("final_wrap_cnt", wrap_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
